// File: rtl/pa_iu_div_ctrl_if.sv
// EX-side request/result bundle for the iterative divider.
// The master side is EX; the slave side is the divider control block.
interface pa_iu_div_ctrl_if;
    logic        ex_div_sel;
    logic [31:0] ex_div_src0;
    logic [31:0] ex_div_src1;
    logic [1:0]  ex_div_func;
    logic        ex_div_flush;
    logic        div_ex_busy;
    logic        div_ex_cmplt;
    logic [31:0] div_ex_result;
    logic        div_flush;

    modport master (
        output ex_div_sel,
        output ex_div_src0,
        output ex_div_src1,
        output ex_div_func,
        output ex_div_flush,
        input  div_ex_busy,
        input  div_ex_cmplt,
        input  div_ex_result,
        input  div_flush
    );

    modport slave (
        input  ex_div_sel,
        input  ex_div_src0,
        input  ex_div_src1,
        input  ex_div_func,
        input  ex_div_flush,
        output div_ex_busy,
        output div_ex_cmplt,
        output div_ex_result,
        output div_flush
    );
endinterface

// File: rtl/pa_iu_div_ctrl.sv
// Radix-4 divider control and operand registers (DIV/DIVU/REM/REMU).
// Optional macro PA_IU_DIV_EARLY_OUT_EN skips ITER when |src0| < |src1|.
module pa_iu_div_ctrl (
    input  logic                   div_clk,
    input  logic                   cpurst_b,
    pa_iu_div_ctrl_if.slave        ex_bus,
    output logic                   div_prepare_src0,
    output logic                   div_prepare_src1,
    output logic                   div_iterating,
    output logic [4:0]             div_ff1_res,
    output logic [31:0]            div_divisor_reg,
    output logic [31:0]            div_quotient_reg,
    output logic [31:0]            div_remainder_reg,
    input  logic                   div_iter_cmplt,
    input  logic [31:0]            div_quotient_reg_updt,
    input  logic [31:0]            div_remainder_reg_updt
);

    typedef enum logic [2:0] {
        IDLE,
        PREP0,
        PREP1,
        ITER,
        CMPLT
    } div_state_e;

    div_state_e  cur_state;
    div_state_e  nxt_state;

    logic [31:0] src0_q;
    logic [31:0] src1_q;
    logic [1:0]  func_q;
    logic        special_q;
    logic [31:0] divisor_q;
    logic [31:0] quotient_q;
    logic [31:0] remainder_q;

    logic        flush;
    logic        req_div0;
    logic        req_ovf;
    logic        req_special;
    logic        is_signed;
    logic [31:0] abs_src0;
    logic [31:0] abs_src1;
    logic        early_out;
    logic [31:0] res_raw;
    logic        res_neg;
    logic [31:0] res_fix;

    // Position of the highest set bit; 0 when no bit is set.
    function automatic logic [4:0] ff1(input logic [31:0] v);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) idx = i[4:0];
        end
        return idx;
    endfunction

    assign flush = ex_bus.ex_div_flush;

    // Special cases are decided from the raw request operands.
    assign req_div0    = (ex_bus.ex_div_src1 == 32'd0);
    assign req_ovf     = ~ex_bus.ex_div_func[0]
                       & (ex_bus.ex_div_src0 == 32'h8000_0000)
                       & (ex_bus.ex_div_src1 == 32'hFFFF_FFFF);
    assign req_special = req_div0 | req_ovf;

    // Magnitudes: only signed ops take the absolute value.
    assign is_signed = ~func_q[0];
    assign abs_src0  = (is_signed & src0_q[31]) ? (~src0_q + 32'd1) : src0_q;
    assign abs_src1  = (is_signed & src1_q[31]) ? (~src1_q + 32'd1) : src1_q;

`ifdef PA_IU_DIV_EARLY_OUT_EN
    assign early_out = (abs_src0 < abs_src1);
`else
    assign early_out = 1'b0;
`endif

    // Sign fix is skipped for special results, which are already final.
    assign res_raw = func_q[1] ? remainder_q : quotient_q;
    assign res_neg = is_signed & ~special_q
                   & (func_q[1] ? src0_q[31] : (src0_q[31] ^ src1_q[31]));
    assign res_fix = res_neg ? (~res_raw + 32'd1) : res_raw;

    // State register.
    always_ff @(posedge div_clk) begin
        if (!cpurst_b) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state and output decode.
    always_comb begin
        nxt_state            = cur_state;
        div_prepare_src0     = 1'b0;
        div_prepare_src1     = 1'b0;
        div_iterating        = 1'b0;
        div_ff1_res          = 5'd0;
        ex_bus.div_ex_busy   = (cur_state != IDLE);
        ex_bus.div_ex_cmplt  = 1'b0;
        ex_bus.div_ex_result = 32'd0;
        ex_bus.div_flush     = flush;
        unique case (cur_state)
            IDLE: begin
                if (ex_bus.ex_div_sel) begin
                    nxt_state = req_special ? CMPLT : PREP0;
                end
            end
            PREP0: begin
                div_prepare_src0 = 1'b1;
                div_ff1_res      = ff1(abs_src0);
                nxt_state        = PREP1;
            end
            PREP1: begin
                div_prepare_src1 = 1'b1;
                div_ff1_res      = ff1(abs_src1);
                nxt_state        = early_out ? CMPLT : ITER;
            end
            ITER: begin
                div_iterating = 1'b1;
                if (div_iter_cmplt) nxt_state = CMPLT;
            end
            CMPLT: begin
                ex_bus.div_ex_cmplt  = ~flush;
                ex_bus.div_ex_result = flush ? 32'd0 : res_fix;
                nxt_state            = IDLE;
            end
            default: nxt_state = IDLE;
        endcase
        if (flush) nxt_state = IDLE;
    end

    // Operand, quotient, remainder and divisor registers.
    always_ff @(posedge div_clk) begin
        if (!cpurst_b) begin
            src0_q      <= 32'd0;
            src1_q      <= 32'd0;
            func_q      <= 2'd0;
            special_q   <= 1'b0;
            divisor_q   <= 32'd0;
            quotient_q  <= 32'd0;
            remainder_q <= 32'd0;
        end else if (flush) begin
            special_q <= 1'b0;
        end else begin
            unique case (cur_state)
                IDLE: begin
                    if (ex_bus.ex_div_sel) begin
                        src0_q    <= ex_bus.ex_div_src0;
                        src1_q    <= ex_bus.ex_div_src1;
                        func_q    <= ex_bus.ex_div_func;
                        special_q <= req_special;
                        if (req_div0) begin
                            quotient_q  <= 32'hFFFF_FFFF;
                            remainder_q <= ex_bus.ex_div_src0;
                        end else if (req_ovf) begin
                            quotient_q  <= 32'h8000_0000;
                            remainder_q <= 32'd0;
                        end
                    end
                end
                PREP0: begin
                    remainder_q <= abs_src0;
                    quotient_q  <= 32'd0;
                end
                PREP1: begin
                    divisor_q <= abs_src1;
                end
                ITER: begin
                    quotient_q  <= div_quotient_reg_updt;
                    remainder_q <= div_remainder_reg_updt;
                end
                default: ;
            endcase
        end
    end

    assign div_divisor_reg   = divisor_q;
    assign div_quotient_reg  = quotient_q;
    assign div_remainder_reg = remainder_q;

endmodule

// File: tb/tb_pa_iu_div_ctrl.sv
// Bench for pa_iu_div_ctrl: directed vectors, corner sequences, random ops.
// Includes a behavioural radix-4 kernel and an arithmetic result model.
module tb_pa_iu_div_ctrl;

    logic        div_clk;
    logic        cpurst_b;
    logic        div_prepare_src0;
    logic        div_prepare_src1;
    logic        div_iterating;
    logic [4:0]  div_ff1_res;
    logic [31:0] div_divisor_reg;
    logic [31:0] div_quotient_reg;
    logic [31:0] div_remainder_reg;
    logic        k_last;
    logic [31:0] q_updt;
    logic [31:0] r_updt;

    pa_iu_div_ctrl_if bus ();

    pa_iu_div_ctrl dut (
        .div_clk                (div_clk),
        .cpurst_b               (cpurst_b),
        .ex_bus                 (bus),
        .div_prepare_src0       (div_prepare_src0),
        .div_prepare_src1       (div_prepare_src1),
        .div_iterating          (div_iterating),
        .div_ff1_res            (div_ff1_res),
        .div_divisor_reg        (div_divisor_reg),
        .div_quotient_reg       (div_quotient_reg),
        .div_remainder_reg      (div_remainder_reg),
        .div_iter_cmplt         (k_last),
        .div_quotient_reg_updt  (q_updt),
        .div_remainder_reg_updt (r_updt)
    );

    initial div_clk = 1'b0;
    always #5 div_clk = ~div_clk;

    // Kernel model: remaining digit count, aligned from the ff1 indices.
    int kp0;
    int k;
    initial begin
        kp0 = 0;
        k   = 0;
    end
    always @(posedge div_clk) begin
        if (div_prepare_src0) kp0 <= int'(div_ff1_res);
        if (div_prepare_src1)
            k <= (kp0 > int'(div_ff1_res)) ? (kp0 - int'(div_ff1_res)) / 2 : 0;
        else if (div_iterating && k > 0)
            k <= k - 1;
    end

    // Kernel model: one restoring radix-4 digit per cycle.
    always_comb begin
        longint rr;
        longint dd;
        int     dig;
        rr  = longint'({32'd0, div_remainder_reg});
        dd  = longint'({32'd0, div_divisor_reg}) << (2 * k);
        dig = 0;
        for (int j = 0; j < 3; j++) begin
            if (rr >= dd) begin
                rr  = rr - dd;
                dig = dig + 1;
            end
        end
        r_updt = rr[31:0];
        q_updt = {div_quotient_reg[29:0], dig[1:0]};
        k_last = (k == 0);
    end

    int n_checks;
    int n_pass;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int msb(input logic [31:0] x);
        for (int i = 31; i >= 0; i--) if (x[i]) return i;
        return 0;
    endfunction

    function automatic logic [31:0] uabs(input logic [1:0] f,
                                         input logic [31:0] x);
        if (!f[0] && x[31]) return 32'd0 - x;
        return x;
    endfunction

    function automatic logic is_special(input logic [1:0] f,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
        return (b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // RISC-V division semantics from plain arithmetic.
    function automatic logic [31:0] ref_res(input logic [1:0] f,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 0) return f[1] ? a : 32'hFFFF_FFFF;
        if (f[0]) return f[1] ? (a % b) : (a / b);
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return f[1] ? 32'd0 : 32'h8000_0000;
        return f[1] ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    function automatic int ref_lat(input logic [1:0] f,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        int d;
        if (is_special(f, a, b)) return 1;
`ifdef PA_IU_DIV_EARLY_OUT_EN
        if (uabs(f, a) < uabs(f, b)) return 3;
`endif
        d = msb(uabs(f, a)) - msb(uabs(f, b));
        if (d < 0) d = 0;
        return 3 + d / 2 + 1;
    endfunction

    // Issue one op in IDLE; returns in the cycle after CMPLT.
    task automatic run_op(input logic [1:0] f, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res,
                          output int lat, output int iters,
                          output logic [4:0] f0, output logic [4:0] f1);
        res = 32'd0;
        lat = -1;
        iters = 0;
        f0 = 5'd0;
        f1 = 5'd0;
        bus.ex_div_sel  = 1'b1;
        bus.ex_div_func = f;
        bus.ex_div_src0 = a;
        bus.ex_div_src1 = b;
        @(posedge div_clk);
        #1;
        bus.ex_div_sel = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (div_prepare_src0) f0 = div_ff1_res;
            if (div_prepare_src1) f1 = div_ff1_res;
            if (div_iterating) iters++;
            if (bus.div_ex_cmplt) begin
                lat = c;
                res = bus.div_ex_result;
                break;
            end
            @(posedge div_clk);
            #1;
        end
        @(posedge div_clk);
        #1;
    endtask

    typedef struct {
        string       name;
        logic [1:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        int          iters;
    } vec_t;

`ifdef PA_IU_DIV_EARLY_OUT_EN
    localparam int EO_LAT = 3;
    localparam int EO_IT  = 0;
`else
    localparam int EO_LAT = 4;
    localparam int EO_IT  = 1;
`endif

    vec_t        vt[11];
    logic [31:0] res;
    int          lat;
    int          iters;
    logic [4:0]  f0;
    logic [4:0]  f1;
    int          seen;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        vt[0]  = '{"divu_100_7",   2'b01, 32'd100, 32'd7, 32'd14, 6, 3};
        vt[1]  = '{"remu_100_7",   2'b11, 32'd100, 32'd7, 32'd2, 6, 3};
        vt[2]  = '{"div_m7_2",     2'b00, 32'hFFFF_FFF9, 32'd2,
                   32'hFFFF_FFFD, 4, 1};
        vt[3]  = '{"rem_m7_2",     2'b10, 32'hFFFF_FFF9, 32'd2,
                   32'hFFFF_FFFF, 4, 1};
        vt[4]  = '{"divu_5_0",     2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0};
        vt[5]  = '{"remu_5_0",     2'b11, 32'd5, 32'd0, 32'd5, 1, 0};
        vt[6]  = '{"div_ovf",      2'b00, 32'h8000_0000, 32'hFFFF_FFFF,
                   32'h8000_0000, 1, 0};
        vt[7]  = '{"rem_ovf",      2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
                   32'd0, 1, 0};
        vt[8]  = '{"divu_max",     2'b01, 32'hFFFF_FFFF, 32'd1,
                   32'hFFFF_FFFF, 19, 16};
        vt[9]  = '{"divu_3_10",    2'b01, 32'd3, 32'd10, 32'd0, EO_LAT, EO_IT};
        vt[10] = '{"remu_3_10",    2'b11, 32'd3, 32'd10, 32'd3, EO_LAT, EO_IT};

        bus.ex_div_sel   = 1'b0;
        bus.ex_div_src0  = 32'd0;
        bus.ex_div_src1  = 32'd0;
        bus.ex_div_func  = 2'd0;
        bus.ex_div_flush = 1'b0;
        cpurst_b = 1'b0;
        repeat (3) @(posedge div_clk);
        #1;
        chk("rst_busy", 32'(bus.div_ex_busy), 32'd0);
        chk("rst_cmplt", 32'(bus.div_ex_cmplt), 32'd0);
        chk("rst_result", bus.div_ex_result, 32'd0);
        chk("rst_strobes", 32'({div_prepare_src0, div_prepare_src1,
                                div_iterating}), 32'd0);
        chk("rst_ff1", 32'(div_ff1_res), 32'd0);
        chk("rst_quot", div_quotient_reg, 32'd0);
        chk("rst_rem", div_remainder_reg, 32'd0);
        chk("rst_divisor", div_divisor_reg, 32'd0);
        cpurst_b = 1'b1;
        @(posedge div_clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            run_op(vt[i].f, vt[i].a, vt[i].b, res, lat, iters, f0, f1);
            chk({vt[i].name, "_res"}, res, vt[i].res);
            chk({vt[i].name, "_lat"}, 32'(lat), 32'(vt[i].lat));
            chk({vt[i].name, "_iters"}, 32'(iters), 32'(vt[i].iters));
        end

        // Flush in the second ITER cycle of a long op.
        bus.ex_div_sel  = 1'b1;
        bus.ex_div_func = 2'b01;
        bus.ex_div_src0 = 32'hFFFF_FFFF;
        bus.ex_div_src1 = 32'd1;
        @(posedge div_clk);
        #1;
        bus.ex_div_sel = 1'b0;
        repeat (3) @(posedge div_clk);
        #1;
        chk("flush_pre_iter", 32'(div_iterating), 32'd1);
        bus.ex_div_flush = 1'b1;
        #1;
        chk("flush_div_flush", 32'(bus.div_flush), 32'd1);
        chk("flush_no_cmplt", 32'(bus.div_ex_cmplt), 32'd0);
        @(posedge div_clk);
        #1;
        bus.ex_div_flush = 1'b0;
        chk("flush_idle", 32'(bus.div_ex_busy), 32'd0);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.div_ex_cmplt) seen = 1;
            @(posedge div_clk);
            #1;
        end
        chk("flush_cmplt_gone", 32'(seen), 32'd0);
        run_op(2'b01, 32'd9, 32'd3, res, lat, iters, f0, f1);
        chk("post_flush_res", res, 32'd3);
        chk("post_flush_lat", 32'(lat), 32'(ref_lat(2'b01, 32'd9, 32'd3)));

        // Flush beats a simultaneous request in IDLE.
        bus.ex_div_sel   = 1'b1;
        bus.ex_div_flush = 1'b1;
        bus.ex_div_src0  = 32'd50;
        bus.ex_div_src1  = 32'd5;
        @(posedge div_clk);
        #1;
        bus.ex_div_sel   = 1'b0;
        bus.ex_div_flush = 1'b0;
        chk("idle_flush_busy", 32'(bus.div_ex_busy), 32'd0);

        // Reset mid-operation drops the op silently.
        bus.ex_div_sel  = 1'b1;
        bus.ex_div_func = 2'b01;
        bus.ex_div_src0 = 32'hFFFF_FFFF;
        bus.ex_div_src1 = 32'd1;
        @(posedge div_clk);
        #1;
        bus.ex_div_sel = 1'b0;
        repeat (4) @(posedge div_clk);
        #1;
        cpurst_b = 1'b0;
        @(posedge div_clk);
        #1;
        chk("midrst_busy", 32'(bus.div_ex_busy), 32'd0);
        chk("midrst_quot", div_quotient_reg, 32'd0);
        chk("midrst_rem", div_remainder_reg, 32'd0);
        cpurst_b = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.div_ex_cmplt || bus.div_ex_busy) seen = 1;
            @(posedge div_clk);
            #1;
        end
        chk("midrst_quiet", 32'(seen), 32'd0);

        // Random ops against the arithmetic model.
        for (int n = 0; n < 300; n++) begin
            logic [1:0]  rf;
            logic [31:0] ra;
            logic [31:0] rb;
            int          sel;
            rf  = 2'($urandom_range(0, 3));
            ra  = $urandom >> $urandom_range(0, 31);
            rb  = $urandom >> $urandom_range(0, 31);
            sel = $urandom_range(0, 15);
            if (sel == 0) rb = 32'd0;
            if (sel == 1) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            if (sel == 2) rb = 32'd1;
            if (sel == 3) ra = ra | 32'h8000_0000;
            run_op(rf, ra, rb, res, lat, iters, f0, f1);
            chk($sformatf("rnd%0d_res f=%0d a=%h b=%h", n, rf, ra, rb),
                res, ref_res(rf, ra, rb));
            chk($sformatf("rnd%0d_lat", n), 32'(lat), 32'(ref_lat(rf, ra, rb)));
            if (!is_special(rf, ra, rb)) begin
                chk($sformatf("rnd%0d_ff1_p0", n), 32'(f0),
                    32'(msb(uabs(rf, ra))));
                chk($sformatf("rnd%0d_ff1_p1", n), 32'(f1),
                    32'(msb(uabs(rf, rb))));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pa_iu_div_ctrl.md
# pa_iu_div_ctrl

Control and operand-register block for the iterative radix-4 integer divider. It accepts a divide request from the EX stage and drives the 2-bit shift kernel through its prepare/iterate protocol. It owns the divisor, quotient and remainder registers that the kernel reads, applies RISC-V DIV/DIVU/REM/REMU sign and special-case rules, and returns the final result to EX.

## Interface
- No parameters.
- Clock and reset: one clock; reset is synchronous and active-low.
- `div_clk` in 1: divider clock; all state changes on its rising edge.
- `cpurst_b` in 1: synchronous active-low reset.
- `ex_div_sel` in 1: request valid; accepted only in IDLE.
- `ex_div_src0` in 32: dividend.
- `ex_div_src1` in 32: divisor.
- `ex_div_func` in 2: operation select.
  - bit0 = unsigned, bit1 = remainder.
  - 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `ex_div_flush` in 1: kill the current operation.
- `div_ex_busy` out 1: high in any state other than IDLE.
- `div_ex_cmplt` out 1: one-cycle result-valid pulse.
- `div_ex_result` out 32: result; valid only while `div_ex_cmplt` is high.
- `div_flush` out 1: equals `ex_div_flush`.
- `div_prepare_src0` out 1: high in PREP0.
- `div_prepare_src1` out 1: high in PREP1.
- `div_iterating` out 1: high in ITER.
- `div_ff1_res` out 5: MSB index (31 − leading zeros) of the operand being prepared; 0 for a zero operand.
  - PREP0: |dividend|.
  - PREP1: |divisor|.
  - Otherwise 0.
- `div_divisor_reg` out 32: |divisor|.
- `div_quotient_reg` out 32: partial quotient.
- `div_remainder_reg` out 32: partial remainder.
- `div_iter_cmplt` in 1: final iteration flag from the kernel.
- `div_quotient_reg_updt` in 32: next quotient value from the kernel.
- `div_remainder_reg_updt` in 32: next remainder value from the kernel.

## Operation
- **States:** IDLE, PREP0, PREP1, ITER, CMPLT.
- **IDLE:**
  - When `ex_div_sel` is high and flush is low: latch src0, src1 and func.
  - Special cases, detected at accept, go straight to CMPLT with the special flag set:
    - src1 == 0: quotient reg = 0xFFFFFFFF, remainder reg = raw src0.
    - Signed op with src0 == 0x80000000 and src1 == 0xFFFFFFFF: quotient reg = 0x80000000, remainder reg = 0.
  - Any other accepted request goes to PREP0.
- **PREP0:**
  - Remainder reg = |src0|. Absolute value is applied only for signed ops; unsigned ops pass the value through.
  - Quotient reg = 0.
  - Next state PREP1.
- **PREP1:**
  - Divisor reg = |src1|.
  - Next state ITER, or CMPLT when the early-out condition holds (see Configuration).
- **ITER:**
  - Every cycle: quotient reg ← `div_quotient_reg_updt`, remainder reg ← `div_remainder_reg_updt`.
  - When `div_iter_cmplt` is high, that cycle's update is still taken and the next state is CMPLT.
- **CMPLT:**
  - `div_ex_cmplt` = 1 for this one cycle; next state IDLE.
  - `div_ex_result` = quotient reg for DIV/DIVU, remainder reg for REM/REMU.
  - Sign fix (signed ops, special flag clear):
    - Quotient is negated when the dividend and divisor signs differ.
    - Remainder is negated when the dividend is negative.
  - With the special flag set, the register value is output unmodified.
- **Flush:**
  - `ex_div_flush` in any state gives next state IDLE and clears the special flag.
  - Suppresses `div_ex_cmplt` in the same cycle.
  - In IDLE, flush wins over a simultaneous `ex_div_sel`; the request is not accepted.
- **Reset:**
  - State IDLE; all registers 0.
  - All outputs 0: busy, cmplt, result, prepare/iterating strobes, ff1.
  - Reset taken mid-operation discards the operation with no cmplt.

## Timing
- Accept happens in cycle 0.
  - PREP0 is cycle 1, PREP1 is cycle 2, ITER starts at cycle 3.
- N iterations, where N = floor(max(p0 − p1, 0) / 2) + 1.
  - p0 = MSB index of |dividend|, p1 = MSB index of |divisor|.
- CMPLT is cycle 3 + N.
  - Minimum 4 cycles, maximum 19 (p0 = 31, p1 = 0).
- Special cases: CMPLT is cycle 1.
- Back-to-back operation: a new accept is possible in the cycle after CMPLT.
- There is no backpressure: EX must consume the result in the CMPLT cycle.
- `div_ex_result` is driven from registers through the sign-fix logic only; it is not an additional pipeline stage.

## Configuration
- Macro: `PA_IU_DIV_EARLY_OUT_EN`.
- **Defined:**
  - In PREP1, if |src0| < |src1| (unsigned compare), go directly to CMPLT.
  - Quotient reg = 0; remainder reg keeps |src0|.
  - Sign fix still applies. CMPLT is cycle 3.
- **Undefined:**
  - Always go to ITER. The kernel clamps its count to 0, runs one iteration that produces digit 00, and CMPLT is cycle 4.
  - Results are identical in both configurations.

## Test plan
- **DIVU** 100 / 7: p0 = 6, p1 = 2, so N = 3 → `div_ex_result` = 14 at cycle 6; REMU with the same operands → 2.
- **DIV** 0xFFFFFFF9 / 2 (−7 / 2) → 0xFFFFFFFD; REM with the same operands → 0xFFFFFFFF.
- **Special cases:**
  - DIVU 5 / 0 → 0xFFFFFFFF at cycle 1; REMU 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
- **Maximum latency:** DIVU 0xFFFFFFFF / 1 → 0xFFFFFFFF at cycle 19; `div_iterating` high for exactly 16 cycles.
- **Flush:** assert `ex_div_flush` in the second ITER cycle.
  - Required response: IDLE the next cycle, no `div_ex_cmplt`, `div_flush` = 1 in the flush cycle.
  - A new DIVU 9 / 3 accepted right after → 3.
- **Early out:** DIVU 3 / 10 → 0 and REMU 3 / 10 → 3, with CMPLT at cycle 3 when `PA_IU_DIV_EARLY_OUT_EN` is defined and at cycle 4 when it is not.
